// File: rtl/tt_um_weight_load.sv
// Weight pin-stream receiver: two planes per row (MSB then LSB) assembled into a packed
// 2-bit signed weight bus. A row is committed whole on its LSB edge, never half-written.
module tt_um_weight_load #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 ena,
    input  logic [6:0]                           ui_param,
    input  logic [MAX_OUT_LEN-1:0]               ui_input,
    output logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]  uo_weights,
    output logic                                 uo_busy,
    output logic                                 uo_done
);
    localparam int ROW_W = (MAX_IN_LEN > 1) ? $clog2(MAX_IN_LEN) : 1;

    typedef enum logic [1:0] {S_MSB, S_LSB, S_HOLD} state_t;

    state_t                                     state;
    logic [ROW_W-1:0]                           row;
    logic [MAX_OUT_LEN-1:0]                     staging;
    logic                                       ena_d;
    logic [MAX_IN_LEN-1:0][2*MAX_OUT_LEN-1:0]   w_q;
    logic [2*MAX_OUT_LEN-1:0]                   row_word;
    logic                                       last_row;
    logic                                       row_wrap;
    logic                                       unused_param;

    // Each weight pairs the staged MSB plane bit with the live LSB plane bit.
    always_comb begin
        row_word = '0;
        for (int i = 0; i < MAX_OUT_LEN; i++)
            row_word[2*i +: 2] = {staging[i], ui_input[i]};
    end

    assign last_row     = (32'(row) == 32'(ui_param[6:3]));
    assign row_wrap     = (32'(row) == MAX_IN_LEN - 1);
    assign uo_weights   = w_q;
    assign unused_param = ^ui_param[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_MSB;
            row     <= '0;
            staging <= '0;
            ena_d   <= 1'b0;
            w_q     <= '0;
            uo_busy <= 1'b0;
            uo_done <= 1'b0;
        end else begin
            ena_d <= ena;
            if (ena_d && !ena) begin
                // Falling enable aborts any transfer; committed rows are retained.
                state   <= S_MSB;
                row     <= '0;
                uo_busy <= 1'b0;
                uo_done <= 1'b0;
            end else if (ena) begin
                case (state)
                    S_MSB: begin
                        staging <= ui_input;
                        uo_busy <= 1'b1;
                        state   <= S_LSB;
                    end
                    S_LSB: begin
                        w_q[row] <= row_word;
                        if (last_row) begin
                            uo_done <= 1'b1;
                            uo_busy <= 1'b0;
                            state   <= S_HOLD;
                        end else begin
                            row   <= row_wrap ? '0 : row + 1'b1;
                            state <= S_MSB;
                        end
                    end
                    S_HOLD: uo_done <= 1'b0;
                    default: state <= S_MSB;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tt_um_weight_load.sv
// Directed bench for the weight-stream receiver: single row, full load, abort, partial
// reload, and asynchronous reset mid-transfer, checked against a row-word model.
module tb_tt_um_weight_load;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic [6:0]   ui_param;
    logic [7:0]   ui_input;
    logic [255:0] uo_weights;
    logic         uo_busy;
    logic         uo_done;

    logic [15:0][15:0] exp_w;
    int checks = 0;
    int errors = 0;

    tt_um_weight_load #(.MAX_IN_LEN(16), .MAX_OUT_LEN(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_param(ui_param),
        .ui_input(ui_input), .uo_weights(uo_weights), .uo_busy(uo_busy), .uo_done(uo_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mkrow(input logic [7:0] msb, input logic [7:0] lsb);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[2*i +: 2] = {msb[i], lsb[i]};
        return w;
    endfunction

    // Sends one row (MSB then LSB plane) and updates the model.
    task automatic send_row(input int r, input logic [7:0] msb, input logic [7:0] lsb);
        ui_input = msb;
        tick();
        ui_input = lsb;
        tick();
        exp_w[r] = mkrow(msb, lsb);
    endtask

    task automatic drop_ena();
        ena = 1'b0;
        tick();
    endtask

    // Random ternary plane pair: each column one of 01, 00, 11.
    task automatic rand_ternary(output logic [7:0] msb, output logic [7:0] lsb);
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(2))
                0: begin msb[i] = 1'b0; lsb[i] = 1'b1; end
                1: begin msb[i] = 1'b0; lsb[i] = 1'b0; end
                default: begin msb[i] = 1'b1; lsb[i] = 1'b1; end
            endcase
        end
    endtask

    initial begin
        logic [7:0] m, l;
        rst_n = 1'b0; ena = 1'b0; ui_param = '0; ui_input = '0;
        exp_w = '0;
        #22;
        chk("rst_weights", uo_weights, exp_w);
        chk("rst_busy", 256'(uo_busy), 256'(0));
        chk("rst_done", 256'(uo_done), 256'(0));
        rst_n = 1'b1;
        tick();

        // Single row: FF then 00 gives 2'b10 in every column of row 0.
        ui_param = 7'd0;
        ena = 1'b1;
        ui_input = 8'hFF;
        tick();
        chk("t1_busy_msb", 256'(uo_busy), 256'(1));
        chk("t1_done_msb", 256'(uo_done), 256'(0));
        ui_input = 8'h00;
        tick();
        exp_w[0] = 16'hAAAA;
        chk("t1_done", 256'(uo_done), 256'(1));
        chk("t1_busy", 256'(uo_busy), 256'(0));
        chk("t1_weights", uo_weights, exp_w);
        tick();
        chk("t1_done_once", 256'(uo_done), 256'(0));
        drop_ena();

        // Full 16-row load; done must fire only after the final row.
        ui_param = 7'(15 << 3);
        ena = 1'b1;
        for (int r = 0; r < 16; r++) begin
            send_row(r, 8'(r), ~8'(r));
            chk($sformatf("t2_done_r%0d", r), 256'(uo_done), 256'(r == 15));
        end
        chk("t2_weights", uo_weights, exp_w);
        ui_input = 8'h5A;
        tick();
        tick();
        chk("t2_hold_weights", uo_weights, exp_w);
        chk("t2_hold_done", 256'(uo_done), 256'(0));
        drop_ena();

        // Abort after row 2 MSB: rows 0-1 new, row 2 untouched, no done.
        ui_param = 7'(3 << 3);
        ena = 1'b1;
        send_row(0, 8'h0F, 8'hF0);
        send_row(1, 8'h33, 8'hCC);
        ui_input = 8'hFF;
        tick();
        chk("t3_busy_mid", 256'(uo_busy), 256'(1));
        drop_ena();
        chk("t3_weights", uo_weights, exp_w);
        chk("t3_done", 256'(uo_done), 256'(0));
        chk("t3_busy", 256'(uo_busy), 256'(0));
        ui_param = 7'd0;
        ena = 1'b1;
        send_row(0, 8'h00, 8'hFF);
        chk("t3_restart_row0", uo_weights, exp_w);
        chk("t3_restart_done", 256'(uo_done), 256'(1));
        drop_ena();

        // Partial reload of rows 0-1 with random ternary data.
        ui_param = 7'(1 << 3);
        ena = 1'b1;
        for (int r = 0; r < 2; r++) begin
            rand_ternary(m, l);
            send_row(r, m, l);
        end
        chk("t4_weights", uo_weights, exp_w);
        chk("t4_done", 256'(uo_done), 256'(1));
        drop_ena();

        // Async reset asserted in the middle of the LSB cycle.
        ui_param = 7'(15 << 3);
        ena = 1'b1;
        ui_input = 8'h81;
        tick();
        ui_input = 8'h7E;
        #2;
        rst_n = 1'b0;
        #1;
        exp_w = '0;
        chk("t5_weights_now", uo_weights, exp_w);
        chk("t5_busy_now", 256'(uo_busy), 256'(0));
        chk("t5_done_now", 256'(uo_done), 256'(0));
        tick();
        chk("t5_weights_held", uo_weights, exp_w);
        chk("t5_done_held", 256'(uo_done), 256'(0));
        ena = 1'b0;
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
